// File: rtl/systolic_feeder_if.sv
// Matrix-load and skewed-stream signals shared by the systolic feeder and its driver.
interface systolic_feeder_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int AW = (N * N > 1) ? $clog2(N * N) : 1;

    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          start;
    logic [N*W-1:0] a_row;
    logic [N*W-1:0] b_col;
    logic          pe_clr;
    logic          busy;
    logic          done;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  a_row, b_col, pe_clr, busy, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output a_row, b_col, pe_clr, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Holds matrices A and B and streams them diagonally skewed into the
// left/top edges of an N x N systolic array, one wavefront per cycle.
module systolic_feeder #(
    parameter int N = 4,
    parameter int W = 8
) (
    input logic            clk,
    input logic            rst,
    systolic_feeder_if.slave bus
);
    localparam int AW    = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int TW    = $clog2(3 * N);
    localparam int TLAST = 3 * N - 3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CLEAR  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    st, st_nxt;
    logic [TW-1:0] t, t_nxt;
    logic [W-1:0]  mem_a [N*N];
    logic [W-1:0]  mem_b [N*N];
    logic [N*W-1:0] a_nxt, b_nxt;
    int            k;

    always_comb begin
        st_nxt = st;
        t_nxt  = t;
        case (st)
            IDLE:   if (bus.start) st_nxt = CLEAR;
            CLEAR: begin
                st_nxt = STREAM;
                t_nxt  = '0;
            end
            STREAM: begin
                if (t == TW'(TLAST)) st_nxt = DONE;
                else                 t_nxt  = t + 1'b1;
            end
            DONE:   st_nxt = bus.start ? CLEAR : IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port is a flop; the
    // memory read here already sees any write committed at the start edge.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            k = int'(t_nxt) - int'(i);
            if (st_nxt == STREAM && k >= 0 && k < N) begin
                a_nxt[i*W +: W] = mem_a[AW'(int'(i) * N + k)];
                b_nxt[i*W +: W] = mem_b[AW'(k * N + int'(i))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            t          <= '0;
            bus.a_row  <= '0;
            bus.b_col  <= '0;
            bus.pe_clr <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            mem_a      <= '{default: '0};
            mem_b      <= '{default: '0};
        end else begin
            st         <= st_nxt;
            t          <= t_nxt;
            bus.a_row  <= a_nxt;
            bus.b_col  <= b_nxt;
            bus.pe_clr <= (st_nxt == CLEAR);
            bus.busy   <= (st_nxt == CLEAR) || (st_nxt == STREAM);
            bus.done   <= (st_nxt == DONE);
            if (bus.wr_en && !bus.busy) begin
                if (bus.wr_sel) mem_b[bus.wr_addr] <= bus.wr_data;
                else            mem_a[bus.wr_addr] <= bus.wr_data;
            end
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized and directed bench for systolic_feeder against a stream-position reference model.
module tb_systolic_feeder;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SL = 3 * N - 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(N), .W(W)) bus();
    systolic_feeder #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int ref_a [N][N];
    int ref_b [N][N];
    // -1 idle, 0 clear, 1..SL stream (t = ph-1), SL+1 done
    int ph = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [N*W-1:0] exp_a();
        logic [N*W-1:0] r = '0;
        int t = ph - 1;
        for (int i = 0; i < N; i++)
            if (ph >= 1 && ph <= SL && t - i >= 0 && t - i < N) r[i*W +: W] = W'(ref_a[i][t-i]);
        return r;
    endfunction

    function automatic logic [N*W-1:0] exp_b();
        logic [N*W-1:0] r = '0;
        int t = ph - 1;
        for (int j = 0; j < N; j++)
            if (ph >= 1 && ph <= SL && t - j >= 0 && t - j < N) r[j*W +: W] = W'(ref_b[t-j][j]);
        return r;
    endfunction

    task automatic tick();
        bit bsy;
        int ad;
        @(posedge clk);
        bsy = (ph >= 0 && ph <= SL);
        if (rst) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ref_a[r][c] = 0;
                    ref_b[r][c] = 0;
                end
            ph = -1;
        end else begin
            if (bus.wr_en && !bsy) begin
                ad = int'(bus.wr_addr);
                if (bus.wr_sel) ref_b[ad / N][ad % N] = int'(bus.wr_data);
                else            ref_a[ad / N][ad % N] = int'(bus.wr_data);
            end
            if (ph == -1 || ph == SL + 1) ph = bus.start ? 0 : -1;
            else ph++;
        end
        #1;
        check("a_row",  64'(bus.a_row),  64'(exp_a()));
        check("b_col",  64'(bus.b_col),  64'(exp_b()));
        check("pe_clr", 64'(bus.pe_clr), 64'(ph == 0));
        check("busy",   64'(bus.busy),   64'(ph >= 0 && ph <= SL));
        check("done",   64'(bus.done),   64'(ph == SL + 1));
    endtask

    task automatic wr(input bit sel, input int addr, input int data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = 4'(addr);
        bus.wr_data = W'(data);
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 3 * N + 4 && ph != -1; k++) tick();
        check("drain_idle", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_a", 64'(bus.a_row), 64'(0));

        // start with nothing written streams zeros
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (SL + 3) tick();

        // identity A, B[r][c] = 4r+c+1
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                wr(1'b0, r * N + c, (r == c) ? 1 : 0);
                wr(1'b1, r * N + c, 4 * r + c + 1);
            end
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("id_clr", 64'(bus.pe_clr), 64'(1));
        tick();
        check("id_t0_a", 64'(bus.a_row), 64'(32'h0000_0001));
        check("id_t0_b", 64'(bus.b_col), 64'(32'h0000_0001));
        tick(); tick();
        check("id_t2_b", 64'(bus.b_col), 64'({8'd0, 8'd3, 8'd6, 8'd9}));
        check("id_t2_a1", 64'(bus.a_row[1*W +: W]), 64'(1));
        repeat (7) tick();
        check("id_pre_done", 64'(bus.done), 64'(0));
        tick();
        check("id_done", 64'(bus.done), 64'(1));
        drain();

        // write and start during STREAM are ignored
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick(); tick();
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'h55; bus.start = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        drain();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        check("bp_a00", 64'(bus.a_row[W-1:0]), 64'(1));
        drain();

        // reset mid-stream at t=5
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        repeat (6) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("mr_busy", 64'(bus.busy), 64'(0));
        check("mr_a", 64'(bus.a_row), 64'(0));
        repeat (3) tick();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        drain();

        // write together with start in IDLE
        bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'hFF; bus.start = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        tick();
        check("sc_a00", 64'(bus.a_row[W-1:0]), 64'(8'hFF));
        drain();

        // start held through DONE restarts without an IDLE gap
        bus.start = 1'b1;
        tick();
        for (int k = 0; k < SL + 2 && bus.done !== 1'b1; k++) tick();
        check("b2b_done", 64'(bus.done), 64'(1));
        tick();
        check("b2b_clr", 64'(bus.pe_clr), 64'(1));
        bus.start = 1'b0;
        drain();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 59) == 0);
            bus.wr_en   = $urandom_range(0, 1) == 1;
            bus.wr_sel  = $urandom_range(0, 1) == 1;
            bus.wr_addr = 4'($urandom_range(0, N * N - 1));
            bus.wr_data = W'($urandom);
            bus.start   = ($urandom_range(0, 7) == 0);
            tick();
        end
        rst = 1'b0; bus.wr_en = 1'b0; bus.start = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
